kaipokrandt_fsm_dispatch: RTL and testbench

//  Instruction sequencer: fetches 16-bit instructions, decodes class, and launches the execution FSMs
//  (reg-ALU, imm-ALU, memory) via start + one-hot dec_* lines, then waits for the selected unit's done.

---
 rtl/kaipokrandt_fsm_dispatch_pkg.sv | 49 ++++
 rtl/kaipokrandt_fsm_dispatch_if.sv | 31 +++
 rtl/kaipokrandt_fsm_dispatch_instr_decode.sv | 21 ++
 rtl/kaipokrandt_fsm_dispatch.sv | 147 ++++++++++++++
 tb/tb_kaipokrandt_fsm_dispatch.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/kaipokrandt_fsm_dispatch_pkg.sv
// ISA definitions for the instruction dispatcher: class codes, field slices,
// decoded-class bundle and dispatcher state encoding.
package kaipokrandt_isa_pkg;

   localparam logic [3:0] CLS_NOP     = 4'h0;
   localparam logic [3:0] CLS_ALU_REG = 4'h1;
   localparam logic [3:0] CLS_ALU_IMM = 4'h2;
   localparam logic [3:0] CLS_LOAD    = 4'h3;
   localparam logic [3:0] CLS_STORE   = 4'h4;
   localparam logic [3:0] CLS_JMP     = 4'h5;
   localparam logic [3:0] CLS_HALT    = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_DECODE    = 3'd2,
      ST_DISPATCH  = 3'd3,
      ST_WAIT_DONE = 3'd4,
      ST_HALT      = 3'd5
   } state_e;

   typedef struct packed {
      logic nop;
      logic alu_reg;
      logic alu_imm;
      logic load;
      logic store;
      logic jmp;
      logic halt;
      logic illegal;
   } dec_t;

   function automatic logic [3:0] ir_cls(input logic [15:0] ir);
      return ir[15:12];
   endfunction

   function automatic logic [3:0] ir_op(input logic [15:0] ir);
      return ir[11:8];
   endfunction

   function automatic logic [3:0] ir_dst(input logic [15:0] ir);
      return ir[7:4];
   endfunction

   function automatic logic [3:0] ir_src(input logic [15:0] ir);
      return ir[3:0];
   endfunction

endpackage

// File: rtl/kaipokrandt_fsm_dispatch_if.sv
// Dispatcher bus: instruction fetch port plus launch/decode/done lines to the
// execution units. master = dispatcher side, slave = memory/execution side.
interface kaipokrandt_fsm_dispatch_if #(
   parameter int AW = 8
);
   logic          mem_rd_req;
   logic [AW-1:0] mem_addr;
   logic          mem_rd_ack;
   logic [15:0]   mem_rdata;
   logic          start;
   logic          dec_alu_reg;
   logic          dec_alu_imm;
   logic          dec_mem;
   logic          mem_is_store;
   logic [3:0]    alu_op;
   logic [3:0]    dst_sel;
   logic [3:0]    src_sel;
   logic [2:0]    unit_done;

   modport master (
      output mem_rd_req, mem_addr, start, dec_alu_reg, dec_alu_imm, dec_mem,
             mem_is_store, alu_op, dst_sel, src_sel,
      input  mem_rd_ack, mem_rdata, unit_done
   );

   modport slave (
      input  mem_rd_req, mem_addr, start, dec_alu_reg, dec_alu_imm, dec_mem,
             mem_is_store, alu_op, dst_sel, src_sel,
      output mem_rd_ack, mem_rdata, unit_done
   );
endinterface

// File: rtl/kaipokrandt_fsm_dispatch_instr_decode.sv
// Combinational instruction-class decoder: ir -> one-hot class + illegal flag.
import kaipokrandt_isa_pkg::*;

module kaipokrandt_instr_decode (
   input  logic [15:0] ir_i,
   output dec_t        dec_o
);
   always_comb begin
      dec_o = '0;
      case (ir_cls(ir_i))
         CLS_NOP:     dec_o.nop     = 1'b1;
         CLS_ALU_REG: dec_o.alu_reg = 1'b1;
         CLS_ALU_IMM: dec_o.alu_imm = 1'b1;
         CLS_LOAD:    dec_o.load    = 1'b1;
         CLS_STORE:   dec_o.store   = 1'b1;
         CLS_JMP:     dec_o.jmp     = 1'b1;
         CLS_HALT:    dec_o.halt    = 1'b1;
         default:     dec_o.illegal = 1'b1;
      endcase
   end
endmodule

// File: rtl/kaipokrandt_fsm_dispatch.sv
// Instruction sequencer: fetch, decode, launch one execution unit, wait for its
// done (with timeout), advance pc. NOP/JMP/HALT are handled here.
//
//   state     | meaning
//   IDLE      | between instructions, waits for run
//   FETCH     | mem_rd_req held until mem_rd_ack, ir captured on ack
//   DECODE    | class decoded from ir, dec_* valid from here on
//   DISPATCH  | one-cycle start pulse, timeout counter cleared
//   WAIT_DONE | waits for selected unit's done bit or timeout
//   HALT      | terminal until reset (HALT class, illegal, timeout)
import kaipokrandt_isa_pkg::*;

module kaipokrandt_fsm_dispatch #(
   parameter int AW          = 8,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          run,
   kaipokrandt_fsm_dispatch_if.master    bus,
   output logic [AW-1:0]                 pc,
   output logic                          busy,
   output logic                          halted,
   output logic                          err_illegal,
   output logic                          err_timeout
);
   localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

   state_e        state_q, state_d;
   logic [15:0]   ir_q, ir_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_ill_q, err_ill_d;
   logic          err_to_q, err_to_d;

   dec_t dec;
   logic in_exec;
   logic sel_alu_reg, sel_alu_imm, sel_mem;
   logic sel_done;
   logic is_unit_cls;

   kaipokrandt_instr_decode u_decode (
      .ir_i  (ir_q),
      .dec_o (dec)
   );

   // dec_* lines stay valid from DECODE through WAIT_DONE and drop on return to IDLE
   assign in_exec     = (state_q == ST_DECODE) || (state_q == ST_DISPATCH) ||
                        (state_q == ST_WAIT_DONE);
   assign sel_alu_reg = in_exec & dec.alu_reg;
   assign sel_alu_imm = in_exec & dec.alu_imm;
   assign sel_mem     = in_exec & (dec.load | dec.store);
   assign is_unit_cls = dec.alu_reg | dec.alu_imm | dec.load | dec.store;
   assign sel_done    = (sel_alu_reg & bus.unit_done[0]) |
                        (sel_alu_imm & bus.unit_done[1]) |
                        (sel_mem     & bus.unit_done[2]);

   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      pc_d      = pc_q;
      cnt_d     = cnt_q;
      err_ill_d = err_ill_q;
      err_to_d  = err_to_q;
      case (state_q)
         ST_IDLE: begin
            if (run) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (bus.mem_rd_ack) begin
               ir_d    = bus.mem_rdata;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (is_unit_cls) begin
               state_d = ST_DISPATCH;
            end else if (dec.nop) begin
               pc_d    = pc_q + AW'(1);
               state_d = ST_IDLE;
            end else if (dec.jmp) begin
               pc_d    = ir_q[AW-1:0];
               state_d = ST_IDLE;
            end else if (dec.halt) begin
               state_d = ST_HALT;
            end else begin
               err_ill_d = 1'b1;
               state_d   = ST_HALT;
            end
         end
         ST_DISPATCH: begin
            cnt_d   = '0;
            state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            // done on the limit cycle still completes normally
            if (sel_done) begin
               pc_d    = pc_q + AW'(1);
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               err_to_d = 1'b1;
               state_d  = ST_HALT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         ir_q      <= '0;
         pc_q      <= '0;
         cnt_q     <= '0;
         err_ill_q <= 1'b0;
         err_to_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         pc_q      <= pc_d;
         cnt_q     <= cnt_d;
         err_ill_q <= err_ill_d;
         err_to_q  <= err_to_d;
      end
   end

   assign bus.mem_rd_req   = (state_q == ST_FETCH);
   assign bus.mem_addr     = (state_q == ST_FETCH) ? pc_q : '0;
   assign bus.start        = (state_q == ST_DISPATCH);
   assign bus.dec_alu_reg  = sel_alu_reg;
   assign bus.dec_alu_imm  = sel_alu_imm;
   assign bus.dec_mem      = sel_mem;
   assign bus.mem_is_store = in_exec & dec.store;
   assign bus.alu_op       = (state_q == ST_HALT) ? 4'h0 : ir_op(ir_q);
   assign bus.dst_sel      = (state_q == ST_HALT) ? 4'h0 : ir_dst(ir_q);
   assign bus.src_sel      = (state_q == ST_HALT) ? 4'h0 : ir_src(ir_q);

   assign pc          = pc_q;
   assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALT);
   assign halted      = (state_q == ST_HALT);
   assign err_illegal = err_ill_q;
   assign err_timeout = err_to_q;
endmodule

// File: tb/tb_kaipokrandt_fsm_dispatch.sv
// Directed testbench for kaipokrandt_fsm_dispatch; inputs driven and outputs
// sampled on the falling clock edge.
module tb_kaipokrandt_fsm_dispatch;
   logic       clk = 1'b0;
   logic       reset;
   logic       run;
   logic [7:0] pc;
   logic       busy, halted, err_illegal, err_timeout;
   int         checks = 0;
   int         failures = 0;
   int         start_cnt = 0;

   kaipokrandt_fsm_dispatch_if #(.AW(8)) bus ();

   kaipokrandt_fsm_dispatch #(.AW(8), .TIMEOUT_CYC(64)) dut (
      .clk         (clk),
      .reset       (reset),
      .run         (run),
      .bus         (bus),
      .pc          (pc),
      .busy        (busy),
      .halted      (halted),
      .err_illegal (err_illegal),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   always begin
      @(posedge clk);
      #2;
      if (bus.start === 1'b1) start_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // call at an IDLE negedge; returns at the DECODE negedge
   task automatic fetch(input logic [15:0] instr);
      run = 1'b1; bus.mem_rd_ack = 1'b1; bus.mem_rdata = instr;
      @(negedge clk); run = 1'b0;
      @(negedge clk); bus.mem_rd_ack = 1'b0; bus.mem_rdata = 16'h0;
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0; run = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if ({busy, halted, err_illegal, err_timeout} !== 4'b0000) begin failures++; $display("FAIL reset_flags: got %b want 0000", {busy, halted, err_illegal, err_timeout}); end
      checks++; if (pc !== 8'h00) begin failures++; $display("FAIL reset_pc: got %0h want 0", pc); end
      checks++; if ({bus.mem_rd_req, bus.start, bus.dec_alu_reg, bus.dec_alu_imm, bus.dec_mem} !== 5'b0) begin failures++; $display("FAIL reset_bus: got %b want 00000", {bus.mem_rd_req, bus.start, bus.dec_alu_reg, bus.dec_alu_imm, bus.dec_mem}); end
      reset = 1'b1; run = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_no_run: busy got %b want 0", busy); end
   endtask

   task automatic test_alu_reg();
      int sc;
      logic bad;
      run = 1'b1; bus.mem_rd_ack = 1'b1; bus.mem_rdata = 16'h1A21;
      @(negedge clk); run = 1'b0;
      checks++; if ({bus.mem_rd_req, busy, bus.mem_addr} !== {2'b11, 8'h00}) begin failures++; $display("FAIL fetch_req: got %b/%b/%0h want 1/1/0", bus.mem_rd_req, busy, bus.mem_addr); end
      @(negedge clk); bus.mem_rd_ack = 1'b0;
      sc = start_cnt;
      checks++; if ({bus.dec_alu_reg, bus.dec_alu_imm, bus.dec_mem, bus.start} !== 4'b1000) begin failures++; $display("FAIL decode_alu_reg: got %b want 1000", {bus.dec_alu_reg, bus.dec_alu_imm, bus.dec_mem, bus.start}); end
      checks++; if ({bus.alu_op, bus.dst_sel, bus.src_sel} !== 12'hA21) begin failures++; $display("FAIL fields: got %0h want a21", {bus.alu_op, bus.dst_sel, bus.src_sel}); end
      @(negedge clk);
      checks++; if ({bus.start, bus.dec_alu_reg} !== 2'b11) begin failures++; $display("FAIL dispatch_start: got %b want 11", {bus.start, bus.dec_alu_reg}); end
      bad = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (bus.start !== 1'b0 || bus.dec_alu_reg !== 1'b1 || busy !== 1'b1 || pc !== 8'h00) bad = 1'b1;
         if (i == 4) bus.unit_done = 3'b001;
      end
      checks++; if (bad !== 1'b0) begin failures++; $display("FAIL wait_hold: got violation %b want 0", bad); end
      @(negedge clk); bus.unit_done = 3'b000;
      checks++; if ({busy, bus.dec_alu_reg, pc} !== {2'b00, 8'h01}) begin failures++; $display("FAIL alu_reg_done: got %b/%b/%0h want 0/0/1", busy, bus.dec_alu_reg, pc); end
      checks++; if (start_cnt - sc !== 1) begin failures++; $display("FAIL start_pulses: got %0d want 1", start_cnt - sc); end
   endtask

   task automatic test_delayed_ack();
      logic bad;
      bad = 1'b0;
      run = 1'b1; bus.mem_rd_ack = 1'b0; bus.mem_rdata = 16'h1111;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk); run = 1'b0;
         if (bus.mem_rd_req !== 1'b1 || bus.mem_addr !== 8'h01 || bus.alu_op !== 4'hA) bad = 1'b1;
         if (i == 3) begin bus.mem_rd_ack = 1'b1; bus.mem_rdata = 16'h0345; end
      end
      checks++; if (bad !== 1'b0) begin failures++; $display("FAIL ack_wait_hold: got violation %b want 0", bad); end
      @(negedge clk); bus.mem_rd_ack = 1'b0; bus.mem_rdata = 16'h0;
      checks++; if ({bus.alu_op, bus.dst_sel, bus.src_sel} !== 12'h345) begin failures++; $display("FAIL ir_on_ack: got %0h want 345", {bus.alu_op, bus.dst_sel, bus.src_sel}); end
      checks++; if ({bus.mem_rd_req, bus.dec_alu_reg, bus.dec_alu_imm, bus.dec_mem} !== 4'b0) begin failures++; $display("FAIL nop_decode: got %b want 0000", {bus.mem_rd_req, bus.dec_alu_reg, bus.dec_alu_imm, bus.dec_mem}); end
      @(negedge clk);
      checks++; if ({busy, pc} !== {1'b0, 8'h02}) begin failures++; $display("FAIL nop_pc: got %b/%0h want 0/2", busy, pc); end
   endtask

   task automatic test_jmp_halt();
      int sc;
      logic bad;
      sc = start_cnt;
      fetch(16'h50FF);
      checks++; if ({bus.dec_alu_reg, bus.dec_alu_imm, bus.dec_mem} !== 3'b0) begin failures++; $display("FAIL jmp_decode: got %b want 000", {bus.dec_alu_reg, bus.dec_alu_imm, bus.dec_mem}); end
      @(negedge clk);
      checks++; if (pc !== 8'hFF) begin failures++; $display("FAIL jmp_ff: got %0h want ff", pc); end
      fetch(16'h0000);
      @(negedge clk);
      checks++; if (pc !== 8'h00) begin failures++; $display("FAIL pc_wrap: got %0h want 0", pc); end
      fetch(16'h5034);
      @(negedge clk);
      checks++; if ({busy, pc} !== {1'b0, 8'h34}) begin failures++; $display("FAIL jmp_34: got %b/%0h want 0/34", busy, pc); end
      checks++; if (start_cnt !== sc) begin failures++; $display("FAIL jmp_no_start: got %0d want %0d", start_cnt, sc); end
      fetch(16'hF000);
      @(negedge clk);
      checks++; if ({halted, busy, pc} !== {2'b10, 8'h34}) begin failures++; $display("FAIL halt: got %b/%b/%0h want 1/0/34", halted, busy, pc); end
      run = 1'b1; bad = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (halted !== 1'b1 || bus.mem_rd_req !== 1'b0 || busy !== 1'b0 || pc !== 8'h34) bad = 1'b1;
      end
      run = 1'b0;
      checks++; if (bad !== 1'b0) begin failures++; $display("FAIL halt_sticky: got violation %b want 0", bad); end
   endtask

   task automatic test_illegal();
      int sc;
      pulse_reset();
      sc = start_cnt;
      fetch(16'h7000);
      checks++; if ({bus.dec_alu_reg, bus.dec_alu_imm, bus.dec_mem, busy} !== 4'b0001) begin failures++; $display("FAIL illegal_decode: got %b want 0001", {bus.dec_alu_reg, bus.dec_alu_imm, bus.dec_mem, busy}); end
      @(negedge clk);
      checks++; if ({err_illegal, halted, busy, err_timeout} !== 4'b1100) begin failures++; $display("FAIL illegal_trap: got %b want 1100", {err_illegal, halted, busy, err_timeout}); end
      repeat (3) @(negedge clk);
      checks++; if (start_cnt !== sc) begin failures++; $display("FAIL illegal_no_start: got %0d want %0d", start_cnt, sc); end
   endtask

   task automatic test_timeout();
      logic bad;
      pulse_reset();
      checks++; if (err_illegal !== 1'b0) begin failures++; $display("FAIL err_clear: got %b want 0", err_illegal); end
      fetch(16'h2BCD);
      checks++; if ({bus.dec_alu_imm, bus.dec_alu_reg, bus.alu_op} !== {2'b10, 4'hB}) begin failures++; $display("FAIL imm_decode: got %b/%b/%0h want 1/0/b", bus.dec_alu_imm, bus.dec_alu_reg, bus.alu_op); end
      @(negedge clk);
      checks++; if (bus.start !== 1'b1) begin failures++; $display("FAIL imm_start: got %b want 1", bus.start); end
      bad = 1'b0;
      for (int i = 1; i <= 64; i++) begin
         @(negedge clk);
         if (halted !== 1'b0 || busy !== 1'b1 || bus.dec_alu_imm !== 1'b1) bad = 1'b1;
         bus.unit_done = i[0] ? 3'b101 : 3'b000;
      end
      checks++; if (bad !== 1'b0) begin failures++; $display("FAIL timeout_early: got violation %b want 0", bad); end
      @(negedge clk); bus.unit_done = 3'b000;
      checks++; if ({halted, err_timeout, err_illegal, busy} !== 4'b1100) begin failures++; $display("FAIL timeout_trap: got %b want 1100", {halted, err_timeout, err_illegal, busy}); end
      checks++; if ({pc, bus.dec_alu_imm, bus.alu_op} !== {8'h00, 1'b0, 4'h0}) begin failures++; $display("FAIL timeout_outs: got %0h/%b/%0h want 0/0/0", pc, bus.dec_alu_imm, bus.alu_op); end
   endtask

   task automatic test_done_at_limit();
      pulse_reset();
      checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL err_to_clear: got %b want 0", err_timeout); end
      fetch(16'h1000);
      @(negedge clk);
      for (int i = 1; i <= 64; i++) begin
         @(negedge clk);
         if (i == 64) bus.unit_done = 3'b001;
      end
      @(negedge clk); bus.unit_done = 3'b000;
      checks++; if ({halted, err_timeout, busy, pc} !== {3'b000, 8'h01}) begin failures++; $display("FAIL done_at_limit: got %b/%b/%b/%0h want 0/0/0/1", halted, err_timeout, busy, pc); end
   endtask

   task automatic test_store();
      fetch(16'h4321);
      checks++; if ({bus.dec_mem, bus.mem_is_store, bus.dec_alu_reg, bus.dec_alu_imm} !== 4'b1100) begin failures++; $display("FAIL store_decode: got %b want 1100", {bus.dec_mem, bus.mem_is_store, bus.dec_alu_reg, bus.dec_alu_imm}); end
      @(negedge clk);
      @(negedge clk); bus.unit_done = 3'b011;
      @(negedge clk);
      checks++; if ({busy, pc} !== {1'b1, 8'h01}) begin failures++; $display("FAIL store_ignore_other: got %b/%0h want 1/1", busy, pc); end
      bus.unit_done = 3'b100;
      @(negedge clk); bus.unit_done = 3'b000;
      checks++; if ({busy, bus.mem_is_store, bus.dec_mem, pc} !== {3'b000, 8'h02}) begin failures++; $display("FAIL store_done: got %b/%b/%b/%0h want 0/0/0/2", busy, bus.mem_is_store, bus.dec_mem, pc); end
   endtask

   task automatic test_reset_in_wait();
      fetch(16'h3000);
      checks++; if ({bus.dec_mem, bus.mem_is_store} !== 2'b10) begin failures++; $display("FAIL load_decode: got %b want 10", {bus.dec_mem, bus.mem_is_store}); end
      repeat (3) @(negedge clk);
      #1 reset = 1'b0;
      #1;
      checks++; if ({busy, halted, bus.dec_mem, pc} !== {3'b000, 8'h00}) begin failures++; $display("FAIL async_reset: got %b/%b/%b/%0h want 0/0/0/0", busy, halted, bus.dec_mem, pc); end
      @(negedge clk); reset = 1'b1; run = 1'b1;
      @(negedge clk); run = 1'b0;
      checks++; if ({bus.mem_rd_req, bus.mem_addr} !== {1'b1, 8'h00}) begin failures++; $display("FAIL restart_fetch: got %b/%0h want 1/0", bus.mem_rd_req, bus.mem_addr); end
      bus.mem_rd_ack = 1'b1; bus.mem_rdata = 16'h0000;
      @(negedge clk); bus.mem_rd_ack = 1'b0;
      @(negedge clk);
      checks++; if ({busy, pc} !== {1'b0, 8'h01}) begin failures++; $display("FAIL restart_nop: got %b/%0h want 0/1", busy, pc); end
   endtask

   initial begin
      reset = 1'b0; run = 1'b0;
      bus.mem_rd_ack = 1'b0; bus.mem_rdata = 16'h0; bus.unit_done = 3'b000;
      @(negedge clk);
      test_reset();
      test_alu_reg();
      test_delayed_ack();
      test_jmp_halt();
      test_illegal();
      test_timeout();
      test_done_at_limit();
      test_store();
      test_reset_in_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
